// File: rtl/dec_scan_seq.sv
// dec_scan_seq: registered one-hot decoder with MANUAL and SCAN modes.
//   MANUAL decodes code `a` one cycle after it is sampled; codes >= OUT_N
//   raise err and leave every line inactive. SCAN steps the active line
//   through 0..OUT_N-1, holding each one for DWELL cycles, and pulses wrap
//   when it returns from OUT_N-1 to 0. When en=0 all lines are inactive.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous reset, active-low
//   en    - active-high enable
//   mode  - 0 = MANUAL, 1 = SCAN
//   a     - code to decode in MANUAL mode
//   y     - registered one-hot output, polarity set by ACT_HI
//   idx   - registered index of the active line (registered code in MANUAL)
//   err   - registered out-of-range flag for MANUAL codes
//   wrap  - one-cycle pulse on SCAN wrap-around
module dec_scan_seq #(
  parameter int SEL_W  = 3,
  parameter int OUT_N  = 6,
  parameter int DWELL  = 4,
  parameter int ACT_HI = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] a,
  output logic [OUT_N-1:0] y,
  output logic [SEL_W-1:0] idx,
  output logic             err,
  output logic             wrap
);

  localparam int CNT_W = $clog2(DWELL) + 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [SEL_W-1:0] IDX_LAST   = SEL_W'(OUT_N - 1);
  localparam logic [SEL_W:0]   OUT_N_EXT  = (SEL_W + 1)'(OUT_N);
  localparam logic [OUT_N-1:0] Y_IDLE     = (ACT_HI != 0) ? '0 : '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MANUAL,
    ST_SCAN
  } state_t;

  state_t           state_q, state_d;
  logic [OUT_N-1:0] y_q, y_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic             wrap_q, wrap_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             line_act;
  logic [OUT_N-1:0] onehot;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    err_d    = 1'b0;
    wrap_d   = 1'b0;
    line_act = 1'b0;

    if (!en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else if (!mode) begin
      state_d = ST_MANUAL;
      idx_d   = a;
      cnt_d   = '0;
      if ({1'b0, a} < OUT_N_EXT) begin
        line_act = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end else begin
      state_d  = ST_SCAN;
      line_act = 1'b1;
      if (state_q != ST_SCAN) begin
        // Any entry into SCAN restarts at line 0 with a fresh dwell.
        idx_d = '0;
        cnt_d = '0;
      end else if (cnt_q == DWELL_LAST) begin
        cnt_d = '0;
        if (idx_q == IDX_LAST) begin
          idx_d  = '0;
          wrap_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Decode from the next index so y and idx update on the same edge.
    onehot = '0;
    for (int unsigned i = 0; i < OUT_N; i++) begin
      if (line_act && (idx_d == SEL_W'(i))) begin
        onehot[i] = 1'b1;
      end
    end
    y_d = (ACT_HI != 0) ? onehot : ~onehot;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      y_q     <= Y_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
      wrap_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      wrap_q  <= wrap_d;
      cnt_q   <= cnt_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign err  = err_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_dec_scan_seq.sv
// Self-checking bench for dec_scan_seq: a default instance (6 lines, DWELL=4,
// active-high) and a variant (5 lines, DWELL=1, active-low).
module tb_dec_scan_seq;

  logic       clk;
  logic       rst_n, en, mode;
  logic [2:0] a;
  logic [5:0] y;
  logic [2:0] idx;
  logic       err, wrap;

  logic       v_rst_n, v_en, v_mode;
  logic [2:0] v_a;
  logic [4:0] v_y;
  logic [2:0] v_idx;
  logic       v_err, v_wrap;

  int checks = 0;
  int errors = 0;

  dec_scan_seq #(.SEL_W(3), .OUT_N(6), .DWELL(4), .ACT_HI(1)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .a(a),
    .y(y), .idx(idx), .err(err), .wrap(wrap)
  );

  dec_scan_seq #(.SEL_W(3), .OUT_N(5), .DWELL(1), .ACT_HI(0)) dut_v (
    .clk(clk), .rst_n(v_rst_n), .en(v_en), .mode(v_mode), .a(v_a),
    .y(v_y), .idx(v_idx), .err(v_err), .wrap(v_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic [5:0] y;
    logic [2:0] idx;
    logic       err;
    logic       wrap;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_main(input string tag, input logic [5:0] ey, input logic [2:0] eidx,
                          input logic eerr, input logic ewrap);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".idx"}, 32'(idx), 32'(eidx));
    chk({tag, ".err"}, 32'(err), 32'(eerr));
    chk({tag, ".wrap"}, 32'(wrap), 32'(ewrap));
  endtask

  task automatic chk_var(input string tag, input logic [4:0] ey, input logic [2:0] eidx,
                         input logic eerr, input logic ewrap);
    chk({tag, ".y"}, 32'(v_y), 32'(ey));
    chk({tag, ".idx"}, 32'(v_idx), 32'(eidx));
    chk({tag, ".err"}, 32'(v_err), 32'(eerr));
    chk({tag, ".wrap"}, 32'(v_wrap), 32'(ewrap));
  endtask

  // Advance one edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [2:0] av,
                              input logic [5:0] ey, input logic [2:0] ei,
                              input logic ee, input logic ew);
    vec_t v;
    v.rst_n = r; v.en = e; v.mode = m; v.a = av;
    v.y = ey; v.idx = ei; v.err = ee; v.wrap = ew;
    return v;
  endfunction

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 1'b0; a = '0;
    v_rst_n = 1'b0; v_en = 1'b0; v_mode = 1'b0; v_a = '0;

    // Reset for two cycles, then idle sweep of a.
    vecs.push_back(mk(1'b0, 1'b0, 1'b0, 3'd0, 6'b000000, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b0, 1'b1, 1'b1, 3'd5, 6'b000000, 3'd0, 1'b0, 1'b0));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'(i), 6'b000000, 3'd0, 1'b0, 1'b0));
    // MANUAL decode of every code, including the two out-of-range ones.
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd0, 6'b000001, 3'd0, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd1, 6'b000010, 3'd1, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd2, 6'b000100, 3'd2, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 6'b001000, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd4, 6'b010000, 3'd4, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd5, 6'b100000, 3'd5, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd6, 6'b000000, 3'd6, 1'b1, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd7, 6'b000000, 3'd7, 1'b1, 1'b0));
    // Dropping en clears y and err but idx keeps its last value.
    vecs.push_back(mk(1'b1, 1'b0, 1'b0, 3'd2, 6'b000000, 3'd7, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b1, 1'b0, 3'd3, 6'b001000, 3'd3, 1'b0, 1'b0));
    vecs.push_back(mk(1'b1, 1'b0, 1'b1, 3'd1, 6'b000000, 3'd3, 1'b0, 1'b0));

    for (int i = 0; i < vecs.size(); i++) begin
      rst_n = vecs[i].rst_n; en = vecs[i].en; mode = vecs[i].mode; a = vecs[i].a;
      step();
      chk_main($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].err, vecs[i].wrap);
    end

    // Full scan: 4 cycles per line, wrap pulse on cycle 25 only.
    en = 1'b1; mode = 1'b1; a = 3'd6;
    for (int k = 1; k <= 30; k++) begin
      int ei;
      ei = ((k - 1) / 4) % 6;
      step();
      chk_main($sformatf("scan%0d", k), 6'(1 << ei), 3'(ei), 1'b0, (k == 25));
    end

    // Drop en for one cycle at idx=3, then restart from line 0.
    en = 1'b0; step();
    en = 1'b1;
    for (int k = 1; k <= 13; k++) step();
    chk_main("int_pre", 6'b001000, 3'd3, 1'b0, 1'b0);
    en = 1'b0; step();
    chk_main("int_off", 6'b000000, 3'd3, 1'b0, 1'b0);
    en = 1'b1; step();
    chk_main("int_restart", 6'b000001, 3'd0, 1'b0, 1'b0);
    step(); step(); step();
    chk_main("int_dwell4", 6'b000001, 3'd0, 1'b0, 1'b0);
    step();
    chk_main("int_adv", 6'b000010, 3'd1, 1'b0, 1'b0);

    // SCAN -> MANUAL at idx=2 decodes a=4; back to SCAN restarts at 0.
    en = 1'b0; step();
    en = 1'b1; a = 3'd4;
    for (int k = 1; k <= 9; k++) step();
    chk_main("sw_scan", 6'b000100, 3'd2, 1'b0, 1'b0);
    mode = 1'b0; step();
    chk_main("sw_manual", 6'b010000, 3'd4, 1'b0, 1'b0);
    mode = 1'b1; step();
    chk_main("sw_rescan", 6'b000001, 3'd0, 1'b0, 1'b0);

    // Reset mid-scan wins over en/mode.
    step(); step(); step(); step(); step();
    chk_main("rst_pre", 6'b000010, 3'd1, 1'b0, 1'b0);
    rst_n = 1'b0; step();
    chk_main("rst_mid", 6'b000000, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1; step();
    chk_main("rst_rel", 6'b000001, 3'd0, 1'b0, 1'b0);

    // Variant: 5 lines, DWELL=1, active-low outputs.
    v_rst_n = 1'b0; step();
    chk_var("v_rst", 5'b11111, 3'd0, 1'b0, 1'b0);
    v_rst_n = 1'b1; v_en = 1'b1; v_mode = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      int ei;
      ei = (k - 1) % 5;
      step();
      chk_var($sformatf("v_scan%0d", k), ~5'(1 << ei), 3'(ei), 1'b0,
              (k > 1) && ((k - 1) % 5 == 0));
    end
    v_mode = 1'b0; v_a = 3'd5; step();
    chk_var("v_man5", 5'b11111, 3'd5, 1'b1, 1'b0);
    v_a = 3'd2; step();
    chk_var("v_man2", 5'b11011, 3'd2, 1'b0, 1'b0);
    v_en = 1'b0; step();
    chk_var("v_idle", 5'b11111, 3'd2, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
